// File: rtl/boxcar_average_filter.sv
// boxcar_average_filter
//
// Running (boxcar) sum and mean over the last L accepted samples, where
// L = 2^min(log2_len, LOG2_DEPTH). Samples are kept in a ring buffer so the
// sum can be updated in O(1): add the newest sample, subtract the one leaving
// the window. Outputs are registered and appear one cycle after the sample
// that completes or advances a full window.
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous reset, active low
//   log2_len        : window length selector (clamped to LOG2_DEPTH)
//   sample_in       : signed input sample, WIDTH bits
//   sample_in_valid : sample_in is accepted this cycle
//   sum_out         : signed sum of the last L samples, ACC_WIDTH bits
//   mean_out        : sum_out arithmetically shifted right by log2(L)
//   out_valid       : one-cycle pulse when sum_out/mean_out update
//   filled          : high while a full window is available (RUN state)

module boxcar_average_filter #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 10,
    localparam int ACC_WIDTH = WIDTH + LOG2_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           log2_len,
    input  logic [WIDTH-1:0]     sample_in,
    input  logic                 sample_in_valid,
    output logic [ACC_WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0]     mean_out,
    output logic                 out_valid,
    output logic                 filled
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [4:0] MAX_LEN = 5'(LOG2_DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Clamp the requested length exponent to the ring depth.
    function automatic logic [4:0] clamp_len(input logic [4:0] req);
        return (req > MAX_LEN) ? MAX_LEN : req;
    endfunction

    // Floor division by 2^sh: plain arithmetic shift, no rounding. The
    // result always fits in WIDTH bits because it is a mean of WIDTH-bit
    // samples.
    function automatic logic signed [WIDTH-1:0] mean_of(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [4:0]                  sh
    );
        return WIDTH'(a >>> sh);
    endfunction

    // State
    state_t                        state_q, state_d;
    logic [4:0]                    len_q, len_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LOG2_DEPTH:0]           fill_cnt_q, fill_cnt_d;
    logic [LOG2_DEPTH-1:0]         wp_q, wp_d;
    logic signed [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic signed [WIDTH-1:0]       mean_q, mean_d;
    logic                          ov_q, ov_d;

    logic [WIDTH-1:0]              ring_q [DEPTH];

    logic [4:0]                    len_clamped;
    logic [LOG2_DEPTH:0]           win_len;
    logic [LOG2_DEPTH-1:0]         rd_addr;
    logic signed [ACC_WIDTH-1:0]   samp_ext;
    logic signed [ACC_WIDTH-1:0]   old_ext;
    logic                          we;

    assign len_clamped = clamp_len(log2_len);
    assign win_len     = (LOG2_DEPTH + 1)'(1) << len_q;

    // When L equals the full depth the low bits of win_len are zero, so the
    // oldest sample is read from the very slot about to be overwritten; the
    // read sees the old contents because the write lands at the clock edge.
    assign rd_addr  = wp_q - win_len[LOG2_DEPTH-1:0];
    assign samp_ext = ACC_WIDTH'($signed(sample_in));
    assign old_ext  = ACC_WIDTH'($signed(ring_q[rd_addr]));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        fill_cnt_d = fill_cnt_q;
        wp_d       = wp_q;
        sum_d      = sum_q;
        mean_d     = mean_q;
        ov_d       = 1'b0;
        we         = 1'b0;

        if (len_clamped != len_q) begin
            // Length change restarts the window; a sample arriving in the
            // same cycle is dropped. Ring contents are left as they are since
            // FILL never reads them.
            len_d      = len_clamped;
            acc_d      = '0;
            fill_cnt_d = '0;
            state_d    = FILL;
        end else if (sample_in_valid) begin
            we   = 1'b1;
            wp_d = wp_q + LOG2_DEPTH'(1);
            case (state_q)
                FILL: begin
                    acc_d      = acc_q + samp_ext;
                    fill_cnt_d = fill_cnt_q + (LOG2_DEPTH + 1)'(1);
                    if (fill_cnt_d == win_len) begin
                        state_d = RUN;
                        ov_d    = 1'b1;
                    end
                end
                RUN: begin
                    acc_d = acc_q + samp_ext - old_ext;
                    ov_d  = 1'b1;
                end
                default: state_d = FILL;
            endcase
            if (ov_d) begin
                sum_d  = acc_d;
                mean_d = mean_of(acc_d, len_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FILL;
            len_q      <= len_clamped;
            acc_q      <= '0;
            fill_cnt_q <= '0;
            wp_q       <= '0;
            sum_q      <= '0;
            mean_q     <= '0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            fill_cnt_q <= fill_cnt_d;
            wp_q       <= wp_d;
            sum_q      <= sum_d;
            mean_q     <= mean_d;
            ov_q       <= ov_d;
        end
    end

    // Sample storage carries no reset; stale entries are never read before
    // being rewritten because every window starts in FILL.
    always_ff @(posedge clk) begin
        if (we) begin
            ring_q[wp_q] <= sample_in;
        end
    end

    assign sum_out   = sum_q;
    assign mean_out  = mean_q;
    assign out_valid = ov_q;
    assign filled    = (state_q == RUN);

endmodule

// File: tb/tb_boxcar_average_filter.sv
module tb_boxcar_average_filter;

    localparam int WIDTH      = 16;
    localparam int LOG2_DEPTH = 4;
    localparam int ACC_WIDTH  = WIDTH + LOG2_DEPTH;

    logic                        clk;
    logic                        rst;
    logic [4:0]                  log2_len;
    logic [WIDTH-1:0]            sample_in;
    logic                        sample_in_valid;
    logic signed [ACC_WIDTH-1:0] sum_out;
    logic signed [WIDTH-1:0]     mean_out;
    logic                        out_valid;
    logic                        filled;

    int checks;
    int failures;

    boxcar_average_filter #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .log2_len        (log2_len),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .sum_out         (sum_out),
        .mean_out        (mean_out),
        .out_valid       (out_valid),
        .filled          (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one valid sample for exactly one rising edge; returns 1 time
    // unit after that edge so the registered outputs can be sampled.
    task automatic push(input int s);
        @(negedge clk);
        sample_in       = WIDTH'(s);
        sample_in_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_len(input logic [4:0] l);
        @(negedge clk);
        log2_len = l;
        idle(1);
    endtask

    task automatic test_reset;
        rst             = 1'b0;
        log2_len        = 5'd2;
        sample_in       = '0;
        sample_in_valid = 1'b0;
        idle(3);
        checks++;
        if (sum_out !== 0 || mean_out !== 0 || out_valid !== 1'b0 || filled !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: sum=%0d mean=%0d ov=%b filled=%b, want 0 0 0 0",
                     sum_out, mean_out, out_valid, filled);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_fill_run;
        int ov_seen;
        ov_seen = 0;
        push(4);  ov_seen += int'(out_valid);
        push(8);  ov_seen += int'(out_valid);
        push(12); ov_seen += int'(out_valid);
        checks++;
        if (ov_seen !== 0 || filled !== 1'b0) begin
            failures++;
            $display("FAIL fill_no_output: ov_count=%0d filled=%b, want 0 0", ov_seen, filled);
        end
        push(16);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 40 || mean_out !== 10) begin
            failures++;
            $display("FAIL l4_first: ov=%b sum=%0d mean=%0d, want 1 40 10", out_valid, sum_out, mean_out);
        end
        push(20);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 56 || mean_out !== 14 || filled !== 1'b1) begin
            failures++;
            $display("FAIL l4_slide: ov=%b sum=%0d mean=%0d filled=%b, want 1 56 14 1",
                     out_valid, sum_out, mean_out, filled);
        end
        idle(2);
        checks++;
        if (out_valid !== 1'b0 || sum_out !== 56 || mean_out !== 14 || filled !== 1'b1) begin
            failures++;
            $display("FAIL hold_on_gap: ov=%b sum=%0d mean=%0d filled=%b, want 0 56 14 1",
                     out_valid, sum_out, mean_out, filled);
        end
        // Gap must not disturb the window: oldest now 12, so 24 gives 12+16+20+24.
        push(24);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 72 || mean_out !== 18) begin
            failures++;
            $display("FAIL after_gap: ov=%b sum=%0d mean=%0d, want 1 72 18", out_valid, sum_out, mean_out);
        end
    endtask

    task automatic test_negative;
        set_len(5'd1);
        push(-3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL l2_fill: ov=%b, want 0", out_valid);
        end
        push(-4);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== -7 || mean_out !== -4) begin
            failures++;
            $display("FAIL l2_negative: ov=%b sum=%0d mean=%0d, want 1 -7 -4", out_valid, sum_out, mean_out);
        end
        push(5);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 1 || mean_out !== 0) begin
            failures++;
            $display("FAIL l2_slide: ov=%b sum=%0d mean=%0d, want 1 1 0", out_valid, sum_out, mean_out);
        end
    endtask

    task automatic test_len1;
        set_len(5'd0);
        push(7);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 7 || mean_out !== 7) begin
            failures++;
            $display("FAIL l1_first: ov=%b sum=%0d mean=%0d, want 1 7 7", out_valid, sum_out, mean_out);
        end
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || sum_out !== 7) begin
            failures++;
            $display("FAIL l1_idle: ov=%b sum=%0d, want 0 7", out_valid, sum_out);
        end
        push(-2);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== -2 || mean_out !== -2) begin
            failures++;
            $display("FAIL l1_second: ov=%b sum=%0d mean=%0d, want 1 -2 -2", out_valid, sum_out, mean_out);
        end
    endtask

    task automatic test_extremes;
        int ov_seen;
        ov_seen = 0;
        set_len(5'd4);
        for (int i = 0; i < 15; i++) begin
            push(32767);
            ov_seen += int'(out_valid);
        end
        checks++;
        if (ov_seen !== 0) begin
            failures++;
            $display("FAIL l16_fill: ov_count=%0d, want 0", ov_seen);
        end
        push(32767);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 524272 || mean_out !== 32767) begin
            failures++;
            $display("FAIL max_pos: ov=%b sum=%0d mean=%0d, want 1 524272 32767", out_valid, sum_out, mean_out);
        end
        for (int i = 0; i < 16; i++) push(-32768);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== -524288 || mean_out !== -32768) begin
            failures++;
            $display("FAIL max_neg: ov=%b sum=%0d mean=%0d, want 1 -524288 -32768", out_valid, sum_out, mean_out);
        end
    endtask

    task automatic test_len_change;
        set_len(5'd2);
        push(1); push(2); push(3); push(4);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 10 || filled !== 1'b1) begin
            failures++;
            $display("FAIL lc_pre: ov=%b sum=%0d filled=%b, want 1 10 1", out_valid, sum_out, filled);
        end
        // Change length in the same cycle as a valid sample: sample is dropped.
        @(negedge clk);
        log2_len        = 5'd1;
        sample_in       = WIDTH'(99);
        sample_in_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || filled !== 1'b0) begin
            failures++;
            $display("FAIL lc_drop: ov=%b filled=%b, want 0 0", out_valid, filled);
        end
        push(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lc_refill: ov=%b, want 0", out_valid);
        end
        push(5);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 8 || mean_out !== 4 || filled !== 1'b1) begin
            failures++;
            $display("FAIL lc_first: ov=%b sum=%0d mean=%0d filled=%b, want 1 8 4 1",
                     out_valid, sum_out, mean_out, filled);
        end
    endtask

    task automatic test_clamp_reset;
        int ov_seen;
        ov_seen = 0;
        set_len(5'd7);
        for (int i = 0; i < 5; i++) push(1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (sum_out !== 0 || mean_out !== 0 || out_valid !== 1'b0 || filled !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: sum=%0d mean=%0d ov=%b filled=%b, want 0 0 0 0",
                     sum_out, mean_out, out_valid, filled);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            push(2);
            ov_seen += int'(out_valid);
        end
        checks++;
        if (ov_seen !== 0) begin
            failures++;
            $display("FAIL clamp_fill: ov_count=%0d, want 0", ov_seen);
        end
        push(2);
        checks++;
        if (out_valid !== 1'b1 || sum_out !== 32 || mean_out !== 2 || filled !== 1'b1) begin
            failures++;
            $display("FAIL clamp_first: ov=%b sum=%0d mean=%0d filled=%b, want 1 32 2 1",
                     out_valid, sum_out, mean_out, filled);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_run();
        test_negative();
        test_len1();
        test_extremes();
        test_len_change();
        test_clamp_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boxcar_average_filter.md
BOXCAR_AVERAGE_FILTER -- requirements
Module: boxcar_average_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width, two's complement.
REQ-002 SHALL have parameter LOG2_DEPTH, default 10: maximum window is 2^LOG2_DEPTH samples; ring buffer depth.
REQ-003 SHALL have derived localparam ACC_WIDTH = WIDTH+LOG2_DEPTH.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port log2_len, input, 5: window length selector, L = 2^min(log2_len, LOG2_DEPTH).
REQ-007 SHALL have port sample_in, input, WIDTH: signed input sample.
REQ-008 SHALL have port sample_in_valid, input, 1: sample_in is accepted this cycle.
REQ-009 SHALL have port sum_out, output, ACC_WIDTH: signed sum of the last L accepted samples.
REQ-010 SHALL have port mean_out, output, WIDTH: sum_out arithmetically right-shifted by the effective log2 length.
REQ-011 SHALL have port out_valid, output, 1: one-cycle pulse when sum_out/mean_out update.
REQ-012 SHALL have port filled, output, 1: high while in RUN state.

Function
REQ-013 SHALL store accepted samples in a 2^LOG2_DEPTH-entry ring buffer written at write pointer wp; wp increments modulo depth on every write.
REQ-014 SHALL read the oldest sample at address (wp - L) mod depth; the read is combinational in the same cycle as the write.
REQ-015 SHALL register the effective length (clamped log2_len) as len_q; any cycle where the clamped input differs from len_q is a length change.
REQ-016 SHALL implement states FILL and RUN; reset enters FILL.
REQ-017 FILL: on valid, write ring, acc <= acc + sample_in, fill_cnt++; when the accepted sample is the L-th, state -> RUN and out_valid pulses with the full-window sum.
REQ-018 RUN: on valid, write ring, acc <= acc + sample_in - oldest, out_valid pulses.
REQ-019 out_valid SHALL be high exactly one cycle after each accepted sample that completes or advances a full window, and low otherwise.
REQ-020 No output is produced during FILL before the L-th sample.
REQ-021 Latency SHALL be 1 cycle: the sample accepted at edge N is included in sum_out at edge N+1.
REQ-022 sum_out and mean_out SHALL hold their value between out_valid pulses.
REQ-023 Length change: len_q <= new value, acc <= 0, fill_cnt <= 0, state -> FILL, out_valid <= 0; a valid sample in the same cycle is discarded; the ring contents are not cleared.
REQ-024 With L=1 (len_q=0), every accepted sample SHALL produce out_valid next cycle with sum_out = mean_out = the sample.
REQ-025 Arithmetic SHALL be signed at ACC_WIDTH, which cannot overflow for any L <= 2^LOG2_DEPTH.
REQ-026 mean_out SHALL be floor(sum/L), i.e. an arithmetic shift, not rounding.
REQ-027 Gaps in sample_in_valid SHALL not alter state, acc or pointers.

Reset
REQ-028 While rst=0: sum_out=0, mean_out=0, out_valid=0, filled=0, acc=0, wp=0, fill_cnt=0, state=FILL, len_q=clamped log2_len.
REQ-029 Assertion mid-operation SHALL abort immediately; after release, the block refills from empty before its first output.

Verification (WIDTH=16, LOG2_DEPTH=4)
REQ-030 log2_len=2, samples 4,8,12,16,20 -> no out_valid for the first 3 samples; after 16: sum 40, mean 10; after 20: sum 56, mean 14, filled=1.
REQ-031 log2_len=1, samples -3,-4 -> sum -7, mean -4; next sample 5 -> sum 1, mean 0.
REQ-032 log2_len=0, samples 7,-2 with an idle cycle between -> out_valid one cycle after each; sum=mean=7, then -2.
REQ-033 log2_len=4, 16 samples of 32767 -> sum 524272, mean 32767; repeat with -32768 -> sum -524288, mean -32768.
REQ-034 Run at L=4, change log2_len to 1 with valid asserted -> that sample dropped, filled=0, next output after 2 new samples equals their sum.
REQ-035 log2_len=7 -> clamped to L=16; pulse rst low mid-window -> all outputs 0, and the first out_valid comes after 16 new samples.
